// File: rtl/shift_seq_pkg.sv
// Shared constants for the shift register sequencer: mode selects, command
// opcodes and FSM state encoding.
package shift_seq_pkg;

    // Per-bit mode select encoding, {sel0, sel1}
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Command opcodes on cmd_op
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: a flop fed by a 4:1 select
// among hold, the bit arriving on a right shift, the bit arriving on a
// left shift, and the parallel load bit.
module usr_bit_cell
    import shift_seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sel0,
    input  logic sel1,
    input  logic shr_in,   // bit moving into this position on shift right
    input  logic shl_in,   // bit moving into this position on shift left
    input  logic par_in,   // parallel load bit
    output logic q
);

    // Select the next bit value by mode; synchronous reset clears the bit
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case ({sel0, sel1})
                MODE_SHR:  q <= shr_in;
                MODE_SHL:  q <= shl_in;
                MODE_LOAD: q <= par_in;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_register_sequencer.sv
// Command-driven controller for a WIDTH-bit universal shift register.
// Accepts one command at a time, steps the per-bit mode selects for the
// required number of cycles and pulses done when finished.
//
// Handshake: cmd_ready is high only in IDLE. A command transfers on a rising
// clk edge where cmd_valid && cmd_ready; cmd_op, cmd_count and cmd_data are
// captured on that edge and the live inputs are ignored afterwards. cmd_valid
// while cmd_ready is low has no effect.
module shift_register_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    output logic             sel0,
    output logic             sel1,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       shift_mode;  // MODE_SHR or MODE_SHL for the active shift
    logic [WIDTH-1:0] data_r;      // captured parallel load value
    logic [1:0]       mode;
    logic             accept;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state == ST_LOAD) || (state == ST_SHIFT);
    assign done      = (state == ST_DONE);

    // Controller FSM: capture the command, count shift cycles, then report done
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            shift_mode <= MODE_HOLD;
            data_r     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        data_r <= cmd_data;
                        if (cmd_op == OP_LOAD) begin
                            state <= ST_LOAD;
                        end else if ((cmd_op == OP_SHR || cmd_op == OP_SHL) &&
                                     (cmd_count != '0)) begin
                            state      <= ST_SHIFT;
                            remaining  <= cmd_count;
                            shift_mode <= (cmd_op == OP_SHR) ? MODE_SHR : MODE_SHL;
                        end else begin
                            // NOP and zero-length shifts complete immediately
                            state <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: state <= ST_DONE;
                ST_SHIFT: begin
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;  // ST_DONE
            endcase
        end
    end

    // Mode selects come purely from the registered state
    always_comb begin
        mode = MODE_HOLD;
        case (state)
            ST_LOAD:  mode = MODE_LOAD;
            ST_SHIFT: mode = shift_mode;
            default:  mode = MODE_HOLD;
        endcase
    end

    assign sel0 = mode[1];
    assign sel1 = mode[0];

    // Register bank; the end cells take the serial inputs
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic shr_src;
        logic shl_src;

        if (i == WIDTH - 1) begin : g_msb
            assign shr_src = ser_in_msb;
        end else begin : g_inner_r
            assign shr_src = q[i+1];
        end

        if (i == 0) begin : g_lsb
            assign shl_src = ser_in_lsb;
        end else begin : g_inner_l
            assign shl_src = q[i-1];
        end

        usr_bit_cell u_cell (
            .clk    (clk),
            .reset  (reset),
            .sel0   (sel0),
            .sel1   (sel1),
            .shr_in (shr_src),
            .shl_in (shl_src),
            .par_in (data_r[i]),
            .q      (q[i])
        );
    end

endmodule
